// File: rtl/boron_dec_key_seq.sv
// boron_dec_key_seq
//   Sequences the Boron decryption key schedule. A final-round 80-bit key
//   state is loaded through a valid/ready port. The block then streams the
//   64-bit decryption round keys, last round first, to the cipher core under
//   a valid/ready handshake. The key register advances one inverse schedule
//   step per accepted round key and is zeroized whenever the block is idle.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no job; key_reg and cnt are zero, key_in_ready high
//   RUN   | streaming round keys; rk_out = key_reg[63:0], rk_round = cnt
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   key_in        80-bit final-round key state for a decryption job
//   key_in_valid  key_in is valid
//   key_in_ready  block accepts a key (IDLE only)
//   abort         cancel the current job and zeroize
//   rk_out        current round key (0 when not valid)
//   rk_round      index of rk_out, NUM_ROUNDS-1 down to 0
//   rk_valid      rk_out is valid
//   rk_ready      consumer accepts rk_out
//   rk_last       rk_valid at round 0
//   busy          job in progress

// Inverse Boron key schedule step: undo the round-counter XOR on bits
// [63:59], undo the S-box on the low nibble, then rotate right by 13.
module Dec_Key_Scheduler #(
  parameter int KEY_W = 80
) (
  input  logic [KEY_W-1:0] Prev_Key,
  input  logic [4:0]       Dec_Counter,
  output logic [KEY_W-1:0] Dec_Updated_Key
);

  function automatic logic [3:0] inv_sbox(input logic [3:0] v);
    logic [3:0] r;
    case (v)
      4'h0: r = 4'hA;
      4'h1: r = 4'h3;
      4'h2: r = 4'h9;
      4'h3: r = 4'hE;
      4'h4: r = 4'h1;
      4'h5: r = 4'hD;
      4'h6: r = 4'hF;
      4'h7: r = 4'h4;
      4'h8: r = 4'hC;
      4'h9: r = 4'h5;
      4'hA: r = 4'h7;
      4'hB: r = 4'h2;
      4'hC: r = 4'h6;
      4'hD: r = 4'h8;
      4'hE: r = 4'h0;
      default: r = 4'hB;
    endcase
    return r;
  endfunction

  logic [KEY_W-1:0] t;

  always_comb begin
    t = Prev_Key;
    t[63:59] = Prev_Key[63:59] ^ Dec_Counter;
    t[3:0] = inv_sbox(Prev_Key[3:0]);
    Dec_Updated_Key = {t[12:0], t[KEY_W-1:13]};
  end

endmodule

module boron_dec_key_seq #(
  parameter int NUM_ROUNDS = 26,
  parameter int KEY_W      = 80
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_in_valid,
  output logic             key_in_ready,
  input  logic             abort,
  output logic [63:0]      rk_out,
  output logic [4:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             rk_last,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [4:0] CNT_INIT = 5'(NUM_ROUNDS - 1);

  state_t           state, state_nxt;
  logic [KEY_W-1:0] key_reg, key_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [KEY_W-1:0] dec_key;
  logic             in_run;

  Dec_Key_Scheduler #(.KEY_W(KEY_W)) u_dec_ks (
    .Prev_Key        (key_reg),
    .Dec_Counter     (cnt),
    .Dec_Updated_Key (dec_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      key_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      key_reg <= key_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    key_nxt   = key_reg;
    cnt_nxt   = cnt;
    if (abort) begin
      // Abort wins over both handshakes; a round key handshaked on this
      // edge is still considered delivered by the consumer.
      state_nxt = IDLE;
      key_nxt   = '0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_in_valid) begin
            state_nxt = RUN;
            key_nxt   = key_in;
            cnt_nxt   = CNT_INIT;
          end
        end
        RUN: begin
          if (rk_ready) begin
            if (cnt == 5'd0) begin
              state_nxt = IDLE;
              key_nxt   = '0;
              cnt_nxt   = '0;
            end else begin
              key_nxt = dec_key;
              cnt_nxt = cnt - 5'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          key_nxt   = '0;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; rk_out is gated so nothing of the
  // key leaks when not valid, even though key_reg is already zero in IDLE.
  assign in_run       = (state == RUN);
  assign key_in_ready = (state == IDLE);
  assign busy         = in_run;
  assign rk_valid     = in_run;
  assign rk_out       = in_run ? key_reg[63:0] : 64'd0;
  assign rk_round     = in_run ? cnt : 5'd0;
  assign rk_last      = in_run && (cnt == 5'd0);

endmodule

// File: tb/tb_boron_dec_key_seq.sv
module tb_boron_dec_key_seq;

  localparam int NR = 26;

  logic        clk;
  logic        rst;
  logic [79:0] key_in;
  logic        key_in_valid;
  logic        key_in_ready;
  logic        abort;
  logic [63:0] rk_out;
  logic [4:0]  rk_round;
  logic        rk_valid;
  logic        rk_ready;
  logic        rk_last;
  logic        busy;

  logic [79:0] s_key_in;
  logic        s_key_in_valid;
  logic        s_key_in_ready;
  logic        s_abort;
  logic [63:0] s_rk_out;
  logic [4:0]  s_rk_round;
  logic        s_rk_valid;
  logic        s_rk_ready;
  logic        s_rk_last;
  logic        s_busy;

  int total;
  int bad;

  boron_dec_key_seq #(.NUM_ROUNDS(NR), .KEY_W(80)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_in_valid(key_in_valid),
    .key_in_ready(key_in_ready), .abort(abort), .rk_out(rk_out),
    .rk_round(rk_round), .rk_valid(rk_valid), .rk_ready(rk_ready),
    .rk_last(rk_last), .busy(busy)
  );

  boron_dec_key_seq #(.NUM_ROUNDS(2), .KEY_W(80)) dut2 (
    .clk(clk), .rst(rst), .key_in(s_key_in), .key_in_valid(s_key_in_valid),
    .key_in_ready(s_key_in_ready), .abort(s_abort), .rk_out(s_rk_out),
    .rk_round(s_rk_round), .rk_valid(s_rk_valid), .rk_ready(s_rk_ready),
    .rk_last(s_rk_last), .busy(s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: forward Boron S-box; the inverse is found by search.
  function automatic logic [3:0] fwd_sbox(input int i);
    case (i)
      0: return 4'hE;  1: return 4'h4;  2: return 4'hB;  3: return 4'h1;
      4: return 4'h7;  5: return 4'h9;  6: return 4'hC;  7: return 4'hA;
      8: return 4'hD;  9: return 4'h2;  10: return 4'h0; 11: return 4'hF;
      12: return 4'h8; 13: return 4'h5; 14: return 4'h3; default: return 4'h6;
    endcase
  endfunction

  function automatic logic [79:0] dec_model(input logic [79:0] k, input int r);
    logic [79:0] x;
    int inv;
    x = k ^ (80'(r) << 59);
    inv = 0;
    for (int i = 0; i < 16; i++)
      if (fwd_sbox(i) == x[3:0]) inv = i;
    x = (x & ~80'hF) | 80'(inv);
    return (x >> 13) | (x << 67);
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 80'(rk_valid), 80'd0);
    chk({tag, "_busy"}, 80'(busy), 80'd0);
    chk({tag, "_rk_out"}, 80'(rk_out), 80'd0);
    chk({tag, "_round"}, 80'(rk_round), 80'd0);
    chk({tag, "_last"}, 80'(rk_last), 80'd0);
    chk({tag, "_kready"}, 80'(key_in_ready), 80'd1);
  endtask

  task automatic load_key(input logic [79:0] key);
    int cyc;
    key_in = key;
    key_in_valid = 1'b1;
    cyc = 0;
    while (!key_in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("load_wait", 80'(cyc < 50), 80'd1);
    @(posedge clk); #1;
    key_in_valid = 1'b0;
  endtask

  // mode 0: ready always; 1: pattern 1,0,0,1; 2: random.
  task automatic stream(input logic [79:0] key, input int mode,
                        input int abort_rd, input int stop_rd);
    logic [79:0] k;
    logic [63:0] exp_rk [NR];
    int idx, cyc;
    bit rdy;
    k = key;
    for (int i = 0; i < NR; i++) begin
      exp_rk[i] = k[63:0];
      if (i < NR - 1) k = dec_model(k, NR - 1 - i);
    end
    idx = 0;
    cyc = 0;
    while (idx < NR && cyc < 400) begin
      chk("rk_valid", 80'(rk_valid), 80'd1);
      chk("rk_round", 80'(rk_round), 80'(NR - 1 - idx));
      chk("rk_out", 80'(rk_out), 80'(exp_rk[idx]));
      chk("rk_last", 80'(rk_last), 80'(idx == NR - 1));
      chk("busy", 80'(busy), 80'd1);
      chk("kready_run", 80'(key_in_ready), 80'd0);
      if (NR - 1 - idx == stop_rd) begin
        rk_ready = 1'b0;
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rk_ready = rdy;
      if (rdy && (NR - 1 - idx == abort_rd)) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        rk_ready = 1'b0;
        chk_idle("abort");
        return;
      end
      @(posedge clk); #1;
      if (rdy) idx++;
      cyc++;
    end
    rk_ready = 1'b0;
    chk("job_keys", 80'(idx), 80'(NR));
    chk_idle("done");
  endtask

  initial begin
    logic [79:0] ka, kb, kc;
    total = 0;
    bad = 0;
    rst = 1'b1;
    key_in = '0;
    key_in_valid = 1'b0;
    abort = 1'b0;
    rk_ready = 1'b0;
    s_key_in = '0;
    s_key_in_valid = 1'b0;
    s_abort = 1'b0;
    s_rk_ready = 1'b0;

    #2;
    chk_idle("reset");
    #10;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_reset");

    // Zero key, ready held high.
    rk_ready = 1'b1;
    load_key(80'h0);
    stream(80'h0, 0, -1, -1);

    // Ready toggling 1,0,0,1 must deliver the same schedule.
    ka = 80'hFFFF_0123_4567_89AB_CDEF;
    load_key(ka);
    stream(ka, 1, -1, -1);

    // key_in_valid held through RUN: second key loads one cycle after round 0.
    kb = {$urandom, $urandom, $urandom};
    kc = {$urandom, $urandom, $urandom};
    load_key(kb);
    key_in = kc;
    key_in_valid = 1'b1;
    stream(kb, 0, -1, -1);
    @(posedge clk); #1;
    key_in_valid = 1'b0;
    chk("reload_valid", 80'(rk_valid), 80'd1);
    chk("reload_round", 80'(rk_round), 80'(NR - 1));
    chk("reload_out", 80'(rk_out), 80'(kc[63:0]));
    stream(kc, 2, -1, -1);

    // Randomised jobs with random back-pressure.
    for (int j = 0; j < 4; j++) begin
      ka = {$urandom, $urandom, $urandom};
      load_key(ka);
      stream(ka, 2, -1, -1);
    end

    // Abort on the round-20 handshake, then a clean restart.
    ka = {$urandom, $urandom, $urandom};
    load_key(ka);
    stream(ka, 0, 20, -1);
    ka = {$urandom, $urandom, $urandom};
    load_key(ka);
    stream(ka, 2, -1, -1);

    // Asynchronous reset mid-cycle while round 10 is presented.
    ka = {$urandom, $urandom, $urandom};
    load_key(ka);
    stream(ka, 2, -1, 10);
    #3;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("after_rst");

    // NUM_ROUNDS=2: load with abort on the same edge is rejected.
    s_key_in = {$urandom, $urandom, $urandom};
    s_key_in_valid = 1'b1;
    s_abort = 1'b1;
    @(posedge clk); #1;
    s_abort = 1'b0;
    chk("nr2_rej_valid", 80'(s_rk_valid), 80'd0);
    chk("nr2_rej_kready", 80'(s_key_in_ready), 80'd1);
    s_rk_ready = 1'b1;
    @(posedge clk); #1;
    s_key_in_valid = 1'b0;
    chk("nr2_r1_valid", 80'(s_rk_valid), 80'd1);
    chk("nr2_r1_round", 80'(s_rk_round), 80'd1);
    chk("nr2_r1_out", 80'(s_rk_out), 80'(s_key_in[63:0]));
    chk("nr2_r1_last", 80'(s_rk_last), 80'd0);
    @(posedge clk); #1;
    kb = dec_model(s_key_in, 1);
    chk("nr2_r0_round", 80'(s_rk_round), 80'd0);
    chk("nr2_r0_out", 80'(s_rk_out), 80'(kb[63:0]));
    chk("nr2_r0_last", 80'(s_rk_last), 80'd1);
    @(posedge clk); #1;
    s_rk_ready = 1'b0;
    chk("nr2_end_valid", 80'(s_rk_valid), 80'd0);
    chk("nr2_end_kready", 80'(s_key_in_ready), 80'd1);
    chk("nr2_end_out", 80'(s_rk_out), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
